// File: rtl/pipe_pkg.sv
// Shared encodings for the ID/EX operand stage: destination-select modes and
// forwarding-source codes.
package pipe_pkg;

  typedef enum logic [1:0] {
    DST_RT   = 2'd0,
    DST_RD   = 2'd1,
    DST_LINK = 2'd2,
    DST_NONE = 2'd3
  } dst_mode_e;

  typedef enum logic [1:0] {
    FWD_STAGE = 2'd0,
    FWD_EXM   = 2'd1,
    FWD_WB    = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding mux for one source register: the younger EX/MEM result
// beats MEM/WB, and register 0 is never forwarded.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] src_i,
  input  logic [W-1:0]  stage_data_i,
  input  logic          exm_wr_i,
  input  logic [AW-1:0] exm_dst_i,
  input  logic [W-1:0]  exm_data_i,
  input  logic          wb_wr_i,
  input  logic [AW-1:0] wb_dst_i,
  input  logic [W-1:0]  wb_data_i,
  output logic [W-1:0]  data_o,
  output logic [1:0]    fwd_o
);

  logic exm_hit, wb_hit;

  assign exm_hit = exm_wr_i && (exm_dst_i != '0) && (exm_dst_i == src_i);
  assign wb_hit  = wb_wr_i  && (wb_dst_i  != '0) && (wb_dst_i  == src_i);

  // NOTE: every output gets a default first so no path through this block
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    data_o = stage_data_i;
    fwd_o  = FWD_STAGE;
    if (exm_hit) begin
      data_o = exm_data_i;
      fwd_o  = FWD_EXM;
    end else if (wb_hit) begin
      data_o = wb_data_i;
      fwd_o  = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with destination/link resolution, capture-time
// write-through, load-use bubble insertion and EX-stage operand forwarding.
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int W        = 32,
  parameter int AW       = 5,
  parameter int LINK_REG = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic [W-1:0]  in_rs_data,
  input  logic [W-1:0]  in_rt_data,
  input  logic [W-1:0]  in_imm,
  input  logic [W-1:0]  in_pc4,
  input  logic          in_alu_src,
  input  logic          in_uses_rt,
  input  logic [1:0]    in_dst_mode,
  input  logic          in_mem_read,
  input  logic          in_reg_write,
  input  logic          hold,
  input  logic          flush,
  input  logic          exm_wr,
  input  logic          wb_wr,
  input  logic [AW-1:0] exm_dst,
  input  logic [AW-1:0] wb_dst,
  input  logic [W-1:0]  exm_data,
  input  logic [W-1:0]  wb_data,
  output logic          out_valid,
  output logic          out_mem_read,
  output logic          out_reg_write,
  output logic [AW-1:0] out_dst,
  output logic [W-1:0]  op_a,
  output logic [W-1:0]  op_b,
  output logic [W-1:0]  store_data,
  output logic [W-1:0]  link_data,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          stall_req
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] dst;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic [W-1:0]  imm;
    logic [W-1:0]  pc4;
    logic          alu_src;
    logic          mem_read;
    logic          reg_write;
  } stage_t;

  stage_t stage_q, stage_d, capture;

  // Resolve the destination once at capture so EX never sees dst_mode.
  always_comb begin
    capture           = '0;
    capture.valid     = in_valid;
    capture.rs        = in_rs;
    capture.rt        = in_rt;
    capture.imm       = in_imm;
    capture.pc4       = in_pc4;
    capture.alu_src   = in_alu_src;
    capture.mem_read  = in_mem_read;
    capture.reg_write = in_reg_write;
    capture.rs_data   = (wb_wr && wb_dst != '0 && wb_dst == in_rs) ? wb_data : in_rs_data;
    capture.rt_data   = (wb_wr && wb_dst != '0 && wb_dst == in_rt) ? wb_data : in_rt_data;
    case (dst_mode_e'(in_dst_mode))
      DST_RT:   capture.dst = in_rt;
      DST_RD:   capture.dst = in_rd;
      DST_LINK: capture.dst = AW'(LINK_REG);
      default: begin
        capture.dst       = '0;
        capture.reg_write = 1'b0;
      end
    endcase
  end

  assign stall_req = in_valid && stage_q.valid && stage_q.mem_read && (stage_q.dst != '0) &&
                     ((stage_q.dst == in_rs) || (in_uses_rt && stage_q.dst == in_rt));

  // A bubble is the all-zero stage word, so reset and squash look identical.
  always_comb begin
    if (flush)          stage_d = '0;
    else if (hold)      stage_d = stage_q;
    else if (stall_req) stage_d = '0;
    else                stage_d = capture;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  fwd_unit #(.W(W), .AW(AW)) u_fwd_a (
    .src_i        (stage_q.rs),
    .stage_data_i (stage_q.rs_data),
    .exm_wr_i     (exm_wr),
    .exm_dst_i    (exm_dst),
    .exm_data_i   (exm_data),
    .wb_wr_i      (wb_wr),
    .wb_dst_i     (wb_dst),
    .wb_data_i    (wb_data),
    .data_o       (op_a),
    .fwd_o        (fwd_a)
  );

  fwd_unit #(.W(W), .AW(AW)) u_fwd_b (
    .src_i        (stage_q.rt),
    .stage_data_i (stage_q.rt_data),
    .exm_wr_i     (exm_wr),
    .exm_dst_i    (exm_dst),
    .exm_data_i   (exm_data),
    .wb_wr_i      (wb_wr),
    .wb_dst_i     (wb_dst),
    .wb_data_i    (wb_data),
    .data_o       (store_data),
    .fwd_o        (fwd_b)
  );

  assign op_b          = stage_q.alu_src ? stage_q.imm : store_data;
  assign link_data     = stage_q.pc4 + W'(4);
  assign out_valid     = stage_q.valid;
  assign out_mem_read  = stage_q.mem_read;
  assign out_reg_write = stage_q.reg_write;
  assign out_dst       = stage_q.dst;

endmodule
